bcd_sub_serial: RTL and testbench

BCD_SUB_SERIAL -- requirements
Module: bcd_sub_serial

---
 rtl/bcd_sub_serial.sv | 152 +++++++++++++++
 tb/tb_bcd_sub_serial.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial
// Digit-serial packed-BCD subtractor: z = x - y - b_in, one digit per clock,
// least significant digit first. Results wrap modulo 10^DIGITS with b_out=1
// when the true difference is negative.
//
// Parameters:
//   DIGITS  number of BCD digits per operand (1..8)
//
// Ports:
//   clk     single clock, rising edge
//   rst     synchronous active-high reset
//   start   begin a subtraction (ignored while busy)
//   x, y    minuend / subtrahend, packed BCD, LS digit at [3:0]
//   b_in    borrow into digit 0
//   busy    high while digits are being processed
//   done    one-cycle pulse when z/b_out/err become valid
//   z       packed BCD difference
//   b_out   borrow out of the MS digit
//   err     invalid-BCD flag
//
// Optional feature macro: BCD_SUB_ERR_CHECK_EN
//   defined   -> err reports any latched x/y digit above 9, valid with done
//   undefined -> err is tied to 0 and no check logic exists
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] x,
  input  logic [4*DIGITS-1:0] y,
  input  logic                b_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] z,
  output logic                b_out,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  x_sh;
  logic [W-1:0]  y_sh;
  logic [IW-1:0] idx;
  logic          borrow;

  logic [4:0]    diff;
  logic [3:0]    dig;
  logic          borrow_nxt;
  logic          last_digit;
  logic [W-1:0]  z_next;

  // Single-digit subtract on the low nibble of the operand shift registers.
  // The 5-bit difference is negative exactly when bit 4 is set, which covers
  // the full range -16..15 even for invalid nibbles.
  always_comb begin
    diff       = {1'b0, x_sh[3:0]} - {1'b0, y_sh[3:0]} - {4'b0000, borrow};
    borrow_nxt = diff[4];
    dig        = diff[4] ? (diff[3:0] + 4'd10) : diff[3:0];
    last_digit = (idx == IW'(DIGITS - 1));
    // New digits enter at the top of z; after DIGITS shifts digit 0 sits at [3:0].
    z_next     = (z >> 4) | (W'(dig) << (W - 4));
  end

  // Control FSM and datapath. Operands are shifted right one digit per RUN
  // cycle; z fills from the top so no variable part-selects are needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      b_out  <= 1'b0;
      idx    <= '0;
      borrow <= 1'b0;
      x_sh   <= '0;
      y_sh   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            x_sh   <= x;
            y_sh   <= y;
            borrow <= b_in;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          z      <= z_next;
          x_sh   <= x_sh >> 4;
          y_sh   <= y_sh >> 4;
          borrow <= borrow_nxt;
          idx    <= idx + 1'b1;
          if (last_digit) begin
            b_out <= borrow_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BCD_SUB_ERR_CHECK_EN
  logic err_acc;
  logic bad_digit;

  // A nibble above 9 in either operand marks the whole operation invalid.
  always_comb begin
    bad_digit = (x_sh[3:0] > 4'd9) || (y_sh[3:0] > 4'd9);
  end

  // err_acc gathers bad digits during RUN; err is published with done and
  // then holds alongside the result until the next operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_acc <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        err_acc <= 1'b0;
      end
    end else if (last_digit) begin
      err <= err_acc | bad_digit;
    end else begin
      err_acc <= err_acc | bad_digit;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial
// Directed, table-driven bench for bcd_sub_serial with DIGITS=4, plus
// hand-written sequences for ignored start, back-to-back start in DONE and
// reset in the middle of RUN. Expected err follows BCD_SUB_ERR_CHECK_EN.
module tb_bcd_sub_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int BOUND  = 20;

`ifdef BCD_SUB_ERR_CHECK_EN
  localparam logic EXP_BAD_ERR = 1'b1;
`else
  localparam logic EXP_BAD_ERR = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         b_out;
  logic         err;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         b;
    logic [W-1:0] z;
    logic         bo;
    logic         e;
  } vec_t;

  vec_t vecs[9];

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .b_out (b_out),
    .err   (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Present operands with start high for exactly one accepted edge.
  task automatic applyStimulus(input logic [W-1:0] xv, input logic [W-1:0] yv,
                               input logic bv);
    x     = xv;
    y     = yv;
    b_in  = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    x     = '0;
    y     = '0;
    b_in  = 1'b0;
  endtask

  // Count edges until done is seen; a timeout is a failed comparison.
  task automatic waitDone(input string name, output int cycles);
    cycles = 0;
    while (!done && cycles < BOUND) begin
      tick();
      cycles++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s done_timeout actual=%0d expected=%0d", name, cycles, DIGITS);
    end
  endtask

  initial begin
    int lat;
    int done_seen;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    x      = '0;
    y      = '0;
    b_in   = 1'b0;

    vecs[0] = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 1'b0, 16'h9998, 1'b1, 1'b0};
    vecs[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0};
    vecs[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[5] = '{16'h5000, 16'h4999, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h0123, 16'h0456, 1'b0, 16'h9667, 1'b1, 1'b0};
    vecs[7] = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0};
    vecs[8] = '{16'h00A0, 16'h0001, 1'b0, 16'h0099, 1'b0, EXP_BAD_ERR};

    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_z", 32'(z), 32'd0);
    checkOutput("reset_bout", 32'(b_out), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);

    // Table-driven vectors: latency, result, and done pulse width.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].b);
      checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      waitDone($sformatf("v%0d", i), lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(DIGITS));
      checkOutput($sformatf("v%0d_z", i), 32'(z), 32'(vecs[i].z));
      checkOutput($sformatf("v%0d_bout", i), 32'(b_out), 32'(vecs[i].bo));
      checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e));
      tick();
      checkOutput($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      tick();
      checkOutput($sformatf("v%0d_z_hold", i), 32'(z), 32'(vecs[i].z));
    end

    // Start again two cycles into RUN with different operands: must be ignored.
    applyStimulus(16'h0042, 16'h0017, 1'b0);
    tick();
    x     = 16'h1111;
    y     = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ign_busy", 32'(busy), 32'd1);
    done_seen = 0;
    lat = 2;
    while (!done && lat < BOUND) begin
      tick();
      lat++;
    end
    checkOutput("ign_latency", 32'(lat), 32'(DIGITS));
    checkOutput("ign_z", 32'(z), 32'h0025);
    checkOutput("ign_bout", 32'(b_out), 32'd0);

    // Back-to-back: start during the DONE cycle goes straight into RUN.
    applyStimulus(16'h0003, 16'h0005, 1'b0);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    checkOutput("b2b_done_low", 32'(done), 32'd0);
    waitDone("b2b", lat);
    checkOutput("b2b_latency", 32'(lat + 1), 32'(DIGITS + 1));
    checkOutput("b2b_z", 32'(z), 32'h9998);
    checkOutput("b2b_bout", 32'(b_out), 32'd1);
    tick();
    tick();

    // Only one done must follow the ignored start sequence; verify no stray pulse.
    for (int i = 0; i < 8; i++) begin
      if (done) done_seen++;
      tick();
    end
    checkOutput("idle_no_done", 32'(done_seen), 32'd0);

    // Reset two cycles into RUN aborts the operation with no done pulse.
    applyStimulus(16'h0042, 16'h0017, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstrun_busy", 32'(busy), 32'd0);
    checkOutput("rstrun_z", 32'(z), 32'd0);
    checkOutput("rstrun_bout", 32'(b_out), 32'd0);
    checkOutput("rstrun_err", 32'(err), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_seen++;
      tick();
    end
    checkOutput("rstrun_no_done", 32'(done_seen), 32'd0);

    // Reset wins over start in the same cycle.
    x     = 16'h0042;
    y     = 16'h0017;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_prio_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
